// File: rtl/tt_top.sv
// rtl/tt_top.sv - TinyTapeout tile user block: up/down counter, PWM generator, status flags
//
// Purpose:
//    Holds an 8-bit loadable up/down counter shown on uo_out, an 8-bit PWM
//    generator driven by a free-running phase and a programmable duty
//    register, and a set of status flags on the upper bidirectional pins.
//
// Ports:
//    clk      in   1  rising-edge clock
//    rst_n    in   1  asynchronous active-low reset
//    ena      in   1  design enable; 0 freezes all state
//    ui_in    in   8  counter load value / duty value
//    uio_in   in   8  [0] CNT_EN, [1] DIR (1 = down), [2] LOAD, [3] DUTY_WR; [7:4] unused
//    uo_out   out  8  counter value
//    uio_out  out  8  [4] PWM, [5] ZERO, [6] WRAP, [7] SYNC; [3:0] = 0
//    uio_oe   out  8  constant 8'hF0

module tt_top (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // Control bits decoded from the low half of the bidirectional bus.
   logic cnt_en;
   logic dir_down;
   logic load;
   logic duty_wr;

   assign cnt_en   = uio_in[0];
   assign dir_down = uio_in[1];
   assign load     = uio_in[2];
   assign duty_wr  = uio_in[3];

   // The upper half of uio_in belongs to pins configured as outputs.
   logic unused_uio_in;
   assign unused_uio_in = ^uio_in[7:4];

   logic [7:0] cnt_q,   cnt_d;
   logic [7:0] duty_q,  duty_d;
   logic [7:0] phase_q, phase_d;
   logic       wrap_q,  wrap_d;

   always_comb begin
      cnt_d   = cnt_q;
      duty_d  = duty_q;
      phase_d = phase_q;
      wrap_d  = wrap_q;

      if (ena) begin
         // Load wins over counting and never flags a wrap, even 8'hFF -> 8'h00.
         wrap_d = 1'b0;
         if (load) begin
            cnt_d = ui_in;
         end else if (cnt_en) begin
            if (dir_down) begin
               cnt_d  = cnt_q - 8'd1;
               wrap_d = (cnt_q == 8'h00);
            end else begin
               cnt_d  = cnt_q + 8'd1;
               wrap_d = (cnt_q == 8'hFF);
            end
         end

         // Duty write is independent of LOAD; both may take ui_in together.
         if (duty_wr) begin
            duty_d = ui_in;
         end

         phase_d = phase_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 8'h00;
         duty_q  <= 8'h00;
         phase_q <= 8'h00;
         wrap_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
         phase_q <= phase_d;
         wrap_q  <= wrap_d;
      end
   end

   // Outputs depend on registers only. A new duty applies to the very next
   // compare, so the period in flight may be partly old and partly new duty.
   logic pwm;
   logic zero;
   logic sync;

   assign pwm  = (phase_q < duty_q);
   assign zero = (cnt_q == 8'h00);
   assign sync = (phase_q == 8'h00);

   assign uo_out  = cnt_q;
   assign uio_out = {sync, wrap_q, zero, pwm, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_top.sv
// tb/tb_tt_top.sv - scoreboard testbench for tt_top
//
// Purpose:
//    Drives tt_top through reset, load/count, priority, PWM duty, enable
//    gating and asynchronous reset cases. A reference model predicts the
//    outputs when each stimulus cycle is driven; predictions are queued and
//    compared after the clock edge.
//
// Ports: none (top-level bench).

module tb_tt_top;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   always #5 clk = ~clk;

   tt_top dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   localparam logic [3:0] C_CNT_EN  = 4'b0001;
   localparam logic [3:0] C_DOWN    = 4'b0010;
   localparam logic [3:0] C_LOAD    = 4'b0100;
   localparam logic [3:0] C_DUTY_WR = 4'b1000;

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   logic [7:0] m_cnt;
   logic [7:0] m_duty;
   logic [7:0] m_phase;
   logic       m_wrap;

   typedef struct packed {
      logic [7:0] uo;
      logic [7:0] uio;
   } exp_t;

   exp_t sb_q[$];

   int pwm_hi;
   int sync_hi;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] m_status();
      return {(m_phase == 8'h00), m_wrap, (m_cnt == 8'h00), (m_phase < m_duty), 4'b0000};
   endfunction

   task automatic m_reset();
      m_cnt   = 8'h00;
      m_duty  = 8'h00;
      m_phase = 8'h00;
      m_wrap  = 1'b0;
   endtask

   // Drive one cycle, push the prediction, clock, then pop and compare.
   task automatic step(input logic e, input logic [7:0] ui, input logic [3:0] ctl);
      exp_t exp;
      ena    = e;
      ui_in  = ui;
      uio_in = {4'hF, ctl};  // upper bits must be ignored by the DUT
      if (e) begin
         if (ctl[2]) begin
            m_cnt  = ui;
            m_wrap = 1'b0;
         end else if (ctl[0]) begin
            if (ctl[1]) begin
               m_wrap = (m_cnt == 8'h00);
               m_cnt  = m_cnt - 8'd1;
            end else begin
               m_wrap = (m_cnt == 8'hFF);
               m_cnt  = m_cnt + 8'd1;
            end
         end else begin
            m_wrap = 1'b0;
         end
         if (ctl[3]) m_duty = ui;
         m_phase = m_phase + 8'd1;
      end
      sb_q.push_back({m_cnt, m_status()});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 32'd1, 32'd0);
      end else begin
         exp = sb_q.pop_front();
         check_val("uo_out", uo_out, exp.uo);
         check_val("uio_out", uio_out, exp.uio);
      end
      check_val("uio_oe", uio_oe, 8'hF0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      m_reset();
      check_val("rst_uo", uo_out, 8'h00);
      check_val("rst_uio", uio_out, 8'hA0);
      check_val("rst_oe", uio_oe, 8'hF0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_pwm(input logic [7:0] duty, input int exp_hi, input string tag);
      do_reset();
      step(1'b1, duty, C_DUTY_WR);
      pwm_hi  = 0;
      sync_hi = 0;
      for (int i = 0; i < 256; i++) begin
         step(1'b1, 8'h00, 4'b0000);
         if (uio_out[4]) pwm_hi++;
         if (uio_out[7]) sync_hi++;
      end
      check_val(tag, pwm_hi, exp_hi);
      check_val({tag, "_sync"}, sync_hi, 1);
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      m_reset();
      #1;
      check_val("init_rst_uo", uo_out, 8'h00);
      check_val("init_rst_uio", uio_out, 8'hA0);
      check_val("init_rst_oe", uio_oe, 8'hF0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset: controls low, counter stays zero.
      for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 4'b0000);
      check_val("idle_cnt", uo_out, 8'h00);

      // Load 0xFE then count up through the wrap.
      step(1'b1, 8'hFE, C_LOAD);
      check_val("load_fe", uo_out, 8'hFE);
      step(1'b1, 8'h00, C_CNT_EN);
      check_val("up_ff", uo_out, 8'hFF);
      step(1'b1, 8'h00, C_CNT_EN);
      check_val("up_00", uo_out, 8'h00);
      check_val("up_wrap_zero", uio_out[6:5], 2'b11);
      step(1'b1, 8'h00, C_CNT_EN);
      check_val("up_01", uo_out, 8'h01);
      check_val("up_wrap_clr", uio_out[6], 1'b0);

      // Count down through the wrap.
      step(1'b1, 8'h01, C_LOAD);
      step(1'b1, 8'h00, C_CNT_EN | C_DOWN);
      check_val("dn_00", uo_out, 8'h00);
      check_val("dn_00_wrap", uio_out[6], 1'b0);
      step(1'b1, 8'h00, C_CNT_EN | C_DOWN);
      check_val("dn_ff", uo_out, 8'hFF);
      check_val("dn_ff_wrap", uio_out[6], 1'b1);

      // Load from 0xFF to 0x00 must not flag a wrap.
      step(1'b1, 8'h00, C_LOAD | C_CNT_EN);
      check_val("load_nowrap", uio_out[6], 1'b0);

      // Load priority over counting.
      step(1'b1, 8'h55, C_LOAD | C_CNT_EN);
      check_val("prio_55", uo_out, 8'h55);

      // Simultaneous load and duty write, both taking ui_in.
      step(1'b1, 8'h80, C_LOAD | C_DUTY_WR);
      for (int i = 0; i < 20; i++) step(1'b1, 8'h00, C_CNT_EN | (($urandom_range(0, 1) != 0) ? C_DOWN : 4'b0000));

      // PWM duty cases.
      run_pwm(8'h40, 64, "pwm_40");
      run_pwm(8'h00, 0, "pwm_00");
      run_pwm(8'hFF, 255, "pwm_ff");

      // Enable gating.
      step(1'b1, 8'h10, C_LOAD);
      for (int i = 0; i < 10; i++) step(1'b0, 8'hAA, C_CNT_EN | C_DUTY_WR);
      check_val("gate_hold", uo_out, 8'h10);
      step(1'b1, 8'h00, C_CNT_EN);
      check_val("gate_resume", uo_out, 8'h11);

      // Asynchronous reset between edges while counting.
      step(1'b1, 8'h33, C_LOAD | C_DUTY_WR);
      step(1'b1, 8'h00, C_CNT_EN);
      step(1'b1, 8'h00, C_CNT_EN);
      #3;
      rst_n = 1'b0;
      #1;
      m_reset();
      check_val("async_uo", uo_out, 8'h00);
      check_val("async_uio", uio_out, 8'hA0);
      check_val("async_oe", uio_oe, 8'hF0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 8'h00, C_CNT_EN);
      check_val("post_async", uo_out, 8'h03);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tt_top.md
# tt_top

Top-level user block for the TinyTapeout tile, wrapped in the standard tile pin set. It provides:
- an 8-bit loadable up/down counter, shown on the dedicated outputs;
- an 8-bit PWM generator with a programmable duty register;
- status flags on the upper bidirectional pins.

It sits directly under the tile harness. It has no submodule dependencies beyond its own registers.

## Interface
Parameters: none.

- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  reset, active-low, asynchronous; one clock; the polarity and synchronicity are fixed
- ena  in  1  design enable; when 0, all state holds
- ui_in  in  8  data bus: counter load value or duty value
- uio_in  in  8  control inputs on bits [3:0]:
  - [0] CNT_EN
  - [1] DIR (0 = up, 1 = down)
  - [2] LOAD
  - [3] DUTY_WR
  - bits [7:4] are ignored
- uo_out  out  8  current counter value CNT
- uio_out  out  8  status outputs:
  - [4] PWM
  - [5] ZERO
  - [6] WRAP
  - [7] SYNC
  - [3:0] are driven 0
- uio_oe  out  8  constant 8'hF0 (bits [7:4] are outputs, [3:0] are inputs)

## Operation
Registers:
- CNT[7:0]: counter
- DUTY[7:0]: PWM duty
- PHASE[7:0]: free-running PWM phase
- WRAP_R: one-cycle wrap flag

Each rising edge with ena=1:
- LOAD=1: CNT <= ui_in. LOAD has priority over counting; CNT_EN/DIR are ignored that cycle.
- Else if CNT_EN=1:
  - DIR=0: CNT <= CNT+1 mod 256.
  - DIR=1: CNT <= CNT-1 mod 256.
- Else CNT holds.
- DUTY_WR=1: DUTY <= ui_in. This is independent of LOAD; both may occur in the same cycle, and both take ui_in.
- PHASE <= PHASE+1 mod 256 every enabled cycle.
- WRAP_R <= 1 iff the counting path was taken and wrapped (255→0 up, or 0→255 down); otherwise 0. A load never sets WRAP_R, even from 255 to 0.

ena=0: CNT, DUTY, PHASE and WRAP_R all hold; outputs continue to reflect the held state.

Outputs, all combinational from registers only (no combinational path from inputs):
- uo_out = CNT.
- PWM = (PHASE < DUTY), unsigned:
  - DUTY=0 → always 0.
  - DUTY=N → high N of every 256 enabled cycles.
  - DUTY=255 → low only when PHASE=255.
- ZERO = (CNT == 0).
- WRAP = WRAP_R.
- SYNC = (PHASE == 0).
- uio_oe = 8'hF0 at all times, including during reset.

## Timing
- Reset (rst_n=0, asynchronous): CNT=0, DUTY=0, PHASE=0, WRAP_R=0, immediately without a clock. Outputs during reset:
  - uo_out=8'h00
  - uio_out=8'hA0 (ZERO=1, SYNC=1, PWM=0, WRAP=0)
  - uio_oe=8'hF0
- Reset deassertion: the first state update occurs on the first rising edge with rst_n=1.
- Latency: inputs are sampled on the rising edge; the effect is visible on the outputs after that edge (1-cycle latency). There is no handshake.
- A new DUTY takes effect on the PHASE compare immediately after the write edge, mid-period. No double-buffering.
- WRAP is high for exactly one cycle after the wrapping edge.
- Reset asserted mid-operation clears all state at once. Partially counted periods are discarded.

## Test plan
- Reset: rst_n=0 → uo_out=0x00, uio_out=0xA0, uio_oe=0xF0; then release and hold controls at 0 for 5 clocks → uo_out stays 0x00.
- Load/count up: ui_in=0xFE with LOAD for 1 clock, then CNT_EN=1, DIR=0 for 3 clocks:
  - uo_out sequence is 0xFE, 0xFF, 0x00, 0x01.
  - WRAP=1 only in the cycle where uo_out=0x00.
  - ZERO=1 in that same cycle.
- Count down/priority:
  - Load 0x01, then CNT_EN=1, DIR=1 for 2 clocks → 0x00, then 0xFF with WRAP=1.
  - LOAD=1 and CNT_EN=1 together with ui_in=0x55 → 0x55, with no increment.
- PWM duty: write DUTY=0x40 right after reset, then run 256 clocks with ena=1 → PWM high for exactly 64 cycles; SYNC high once per 256 cycles.
  - DUTY=0x00 → PWM never high.
  - DUTY=0xFF → PWM high for 255 cycles.
- Enable gating: CNT=0x10 with CNT_EN=1, then ena=0 for 10 clocks → uo_out stays 0x10 and PHASE/SYNC are frozen; ena=1 resumes at 0x11.
- Async reset mid-run: assert rst_n=0 between clock edges while counting → outputs return to reset values before the next edge.
